byte_striping_tx: RTL and testbench
===================================

BYTE_STRIPING_TX -- requirements
Module: byte_striping_tx

Interface
REQ-001 SHALL have parameter PAD_BYTE, default 8'hBC, byte value inserted into unfilled lanes on flush.
REQ-002 SHALL have parameter NUM_LANES, default 4, fixed at 4 (other values unsupported).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port valid_in  input  1  data_in carries a byte this cycle.
REQ-006 SHALL have port data_in  input  8  serial byte stream.
REQ-007 SHALL have port flush  input  1  close the partial group, padding the remaining lanes.
REQ-008 SHALL have ports data_out0, data_out1, data_out2, data_out3  output  8 each  lane bytes of the committed group.
REQ-009 SHALL have port valid_out  output  1  one-cycle strobe marking a committed group on data_out0..3.
REQ-010 SHALL have port pad_mask  output  4  bit i set = lane i holds PAD_BYTE in the committed group.
REQ-011 SHALL have port group_count  output  16  number of groups committed since reset, wraps.

Function
REQ-012 SHALL stripe bytes round-robin: byte k of a group goes to lane k (0..3), in arrival order.
REQ-013 SHALL use a one-hot FSM with states LANE0, LANE1, LANE2, LANE3, where LANEn means the next accepted byte goes to lane n.
REQ-014 SHALL, on valid_in in state LANEn, store data_in in hold register n and advance to LANE(n+1); LANE3 advances to LANE0.
REQ-015 SHALL hold the current state and all hold registers when valid_in=0 and flush=0.
REQ-016 SHALL, on valid_in in LANE3, commit hold0..2 plus data_in to data_out0..3 at the next edge, with valid_out=1 and pad_mask=4'b0000.
REQ-017 SHALL give a latency of 1 cycle from acceptance of the 4th byte to valid_out.
REQ-018 SHALL, on flush with valid_in=0 in LANEn (n=1..3), commit lanes 0..n-1 from the hold registers, drive lanes n..3 with PAD_BYTE, set pad_mask bits n..3, and return to LANE0.
REQ-019 SHALL, on flush with valid_in=1 in LANEn, accept the byte into lane n first, then commit lanes n+1..3 padded.
REQ-020 SHALL treat flush+valid_in in LANE3 as a normal full commit with pad_mask=0.
REQ-021 SHALL ignore flush in LANE0 with valid_in=0: no valid_out, group_count unchanged.
REQ-022 SHALL, on flush with valid_in=1 in LANE0, commit data_in on lane 0 with pad_mask=4'b1110.
REQ-023 SHALL hold valid_out high for exactly one cycle per commit; back-to-back commits produce consecutive strobes.
REQ-024 SHALL keep data_out0..3 and pad_mask stable at their last committed values while valid_out=0.
REQ-025 SHALL increment group_count by 1 on every commit, wrapping from 16'hFFFF to 0.

Reset
REQ-026 SHALL, while reset=1 at a clk edge, set state to LANE0, the hold registers to 0, data_out0..3 to 8'h00, valid_out to 0, pad_mask to 4'b0000 and group_count to 0.
REQ-027 SHALL give reset priority over valid_in and flush; a partial group in progress at reset is discarded and never emitted.

Structure
REQ-028 SHALL place the lane-state one-hot encoding, NUM_LANES and the default PAD_BYTE in shared package byte_striping_pkg, which the striping RX side reuses.
REQ-029 SHALL implement the hold registers plus output mux of each lane as sub-module byte_striping_lane_buf, instantiated 4 times.
REQ-030 SHALL register all outputs, with no combinational path from any input to any output.

Verification
REQ-031 SHALL cover: bytes 11,22,33,44 on consecutive valid cycles -> next cycle data_out0..3=11,22,33,44, valid_out=1, pad_mask=0, group_count=1.
REQ-032 SHALL cover: bytes 01,02 then flush alone -> data_out=01,02,BC,BC, pad_mask=4'b1100, state LANE0.
REQ-033 SHALL cover: bytes A1,A2,A3 with valid_in gaps of 2 idle cycles between them, then A4 -> single strobe with A1..A4, no strobe earlier.
REQ-034 SHALL cover: byte 55 with flush in LANE0 -> data_out0=55, lanes 1..3=BC, pad_mask=4'b1110.
REQ-035 SHALL cover: 3 bytes accepted, then reset, then 4 new bytes 66..69 -> only one strobe, carrying 66..69, and group_count=1.
REQ-036 SHALL cover: preload group_count to 16'hFFFF via 65535 groups, then one more group -> group_count=0.

Source files
------------

// File: rtl/byte_striping_pkg.sv
// Shared definitions for the byte-striping TX/RX pair: lane count, default pad
// byte and the one-hot lane-state encoding.
package byte_striping_pkg;

  localparam int unsigned NUM_LANES        = 4;
  localparam int unsigned LANE_IDX_W       = 2;
  localparam int unsigned BYTE_W           = 8;
  localparam logic [7:0]  DEFAULT_PAD_BYTE = 8'hBC;

  // LANEn: the next accepted byte is written to lane n.
  typedef enum logic [NUM_LANES-1:0] {
    LANE0 = 4'b0001,
    LANE1 = 4'b0010,
    LANE2 = 4'b0100,
    LANE3 = 4'b1000
  } lane_state_e;

  function automatic logic [LANE_IDX_W-1:0] lane_idx(input lane_state_e s);
    logic [LANE_IDX_W-1:0] idx;
    idx = 2'd0;
    case (s)
      LANE0:   idx = 2'd0;
      LANE1:   idx = 2'd1;
      LANE2:   idx = 2'd2;
      LANE3:   idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/byte_striping_lane_buf.sv
// One striping lane: a hold register for the byte in flight plus the registered
// lane output, which takes the held byte, the live input byte, or the pad byte.
module byte_striping_lane_buf
  import byte_striping_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = DEFAULT_PAD_BYTE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold_we_i,
  input  logic              commit_i,
  input  logic              take_in_i,
  input  logic              pad_i,
  input  logic [BYTE_W-1:0] data_i,
  output logic [BYTE_W-1:0] data_o
);

  logic [BYTE_W-1:0] hold_q, hold_d;
  logic [BYTE_W-1:0] out_q, out_d;

  // Output keeps the last committed value between commits.
  always_comb begin
    hold_d = hold_q;
    out_d  = out_q;
    if (hold_we_i) begin
      hold_d = data_i;
    end
    if (commit_i) begin
      if (pad_i) begin
        out_d = PAD_BYTE;
      end else if (take_in_i) begin
        out_d = data_i;
      end else begin
        out_d = hold_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
      out_q  <= '0;
    end else begin
      hold_q <= hold_d;
      out_q  <= out_d;
    end
  end

  assign data_o = out_q;

endmodule

// File: rtl/byte_striping_tx.sv
// Byte-striping transmitter: distributes a serial byte stream round-robin over
// four lanes and emits each completed (or flushed, padded) group as a strobe.
module byte_striping_tx
  import byte_striping_pkg::*;
#(
  parameter logic [7:0]  PAD_BYTE  = byte_striping_pkg::DEFAULT_PAD_BYTE,
  parameter int unsigned NUM_LANES = byte_striping_pkg::NUM_LANES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [7:0]  data_in,
  input  logic        flush,
  output logic [7:0]  data_out0,
  output logic [7:0]  data_out1,
  output logic [7:0]  data_out2,
  output logic [7:0]  data_out3,
  output logic        valid_out,
  output logic [3:0]  pad_mask,
  output logic [15:0] group_count
);

  lane_state_e state_q, state_d;

  logic                  commit_c;
  logic [LANE_IDX_W-1:0] cur_c;
  logic [LANE_IDX_W:0]   fill_c;
  logic [3:0]            hold_we_c;
  logic [3:0]            take_in_c;
  logic [3:0]            pad_c;

  logic        valid_out_q, valid_out_d;
  logic [3:0]  pad_mask_q, pad_mask_d;
  logic [15:0] group_count_q, group_count_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= LANE0;
      valid_out_q   <= 1'b0;
      pad_mask_q    <= 4'b0000;
      group_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      valid_out_q   <= valid_out_d;
      pad_mask_q    <= pad_mask_d;
      group_count_q <= group_count_d;
    end
  end

  // A group closes on the fourth byte, or on flush unless nothing is pending.
  always_comb begin
    state_d       = state_q;
    commit_c      = 1'b0;
    hold_we_c     = 4'b0000;
    take_in_c     = 4'b0000;
    pad_c         = 4'b0000;
    valid_out_d   = 1'b0;
    pad_mask_d    = pad_mask_q;
    group_count_d = group_count_q;

    cur_c  = lane_idx(state_q);
    fill_c = {1'b0, cur_c} + {2'b00, valid_in};

    if (valid_in) begin
      hold_we_c[cur_c] = 1'b1;
    end

    commit_c = (valid_in && (state_q == LANE3)) ||
               (flush && (valid_in || (state_q != LANE0)));

    if (commit_c) begin
      take_in_c[cur_c] = valid_in;
      for (int i = 0; i < 4; i++) begin
        pad_c[i] = (3'(i) >= fill_c);
      end
      state_d       = LANE0;
      valid_out_d   = 1'b1;
      pad_mask_d    = pad_c;
      group_count_d = group_count_q + 16'd1;
    end else if (valid_in) begin
      case (state_q)
        LANE0:   state_d = LANE1;
        LANE1:   state_d = LANE2;
        LANE2:   state_d = LANE3;
        LANE3:   state_d = LANE0;
        default: state_d = LANE0;
      endcase
    end
  end

  logic [7:0] lane_data [NUM_LANES];

  for (genvar g = 0; g < int'(NUM_LANES); g++) begin : g_lane
    byte_striping_lane_buf #(
      .PAD_BYTE (PAD_BYTE)
    ) u_lane_buf (
      .clk       (clk),
      .reset     (reset),
      .hold_we_i (hold_we_c[g]),
      .commit_i  (commit_c),
      .take_in_i (take_in_c[g]),
      .pad_i     (pad_c[g]),
      .data_i    (data_in),
      .data_o    (lane_data[g])
    );
  end

  assign data_out0   = lane_data[0];
  assign data_out1   = lane_data[1];
  assign data_out2   = lane_data[2];
  assign data_out3   = lane_data[3];
  assign valid_out   = valid_out_q;
  assign pad_mask    = pad_mask_q;
  assign group_count = group_count_q;

endmodule

// File: tb/tb_byte_striping_tx.sv
// Directed self-checking bench for byte_striping_tx.
module tb_byte_striping_tx;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic [7:0]  data_in;
  logic        flush;
  logic [7:0]  data_out0, data_out1, data_out2, data_out3;
  logic        valid_out;
  logic [3:0]  pad_mask;
  logic [15:0] group_count;

  int checks;
  int failures;
  int strobes;

  byte_striping_tx #(
    .PAD_BYTE  (8'hBC),
    .NUM_LANES (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .flush       (flush),
    .data_out0   (data_out0),
    .data_out1   (data_out1),
    .data_out2   (data_out2),
    .data_out3   (data_out3),
    .valid_out   (valid_out),
    .pad_mask    (pad_mask),
    .group_count (group_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic tick(input logic v, input logic [7:0] d, input logic f);
    valid_in = v;
    data_in  = d;
    flush    = f;
    @(posedge clk);
    #1;
    if (valid_out) strobes++;
    valid_in = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic check_group(input string tag, input logic [31:0] exp_data,
                             input logic [3:0] exp_mask, input logic [15:0] exp_cnt);
    check({tag, ".valid"}, 32'(valid_out), 32'd1);
    check({tag, ".data"}, {data_out0, data_out1, data_out2, data_out3}, exp_data);
    check({tag, ".mask"}, 32'(pad_mask), 32'(exp_mask));
    check({tag, ".count"}, 32'(group_count), 32'(exp_cnt));
  endtask

  int s0;

  initial begin
    checks   = 0;
    failures = 0;
    strobes  = 0;
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    flush    = 1'b0;

    // Reset with competing valid/flush must still clear everything.
    tick(1'b1, 8'hEE, 1'b1);
    tick(1'b0, 8'h00, 1'b0);
    check("rst.valid", 32'(valid_out), 32'd0);
    check("rst.data", {data_out0, data_out1, data_out2, data_out3}, 32'h0);
    check("rst.mask", 32'(pad_mask), 32'd0);
    check("rst.count", 32'(group_count), 32'd0);
    reset = 1'b0;

    // Full group of four.
    tick(1'b1, 8'h11, 1'b0);
    tick(1'b1, 8'h22, 1'b0);
    tick(1'b1, 8'h33, 1'b0);
    check("full.no_early", 32'(valid_out), 32'd0);
    tick(1'b1, 8'h44, 1'b0);
    check_group("full", 32'h11223344, 4'b0000, 16'd1);
    tick(1'b0, 8'h99, 1'b0);
    check("full.strobe_len", 32'(valid_out), 32'd0);
    check("full.hold_data", {data_out0, data_out1, data_out2, data_out3}, 32'h11223344);

    // Two bytes then bare flush.
    tick(1'b1, 8'h01, 1'b0);
    tick(1'b1, 8'h02, 1'b0);
    tick(1'b0, 8'h00, 1'b1);
    check_group("flush2", 32'h0102BCBC, 4'b1100, 16'd2);
    // Back in LANE0: a bare flush is ignored.
    tick(1'b0, 8'h00, 1'b1);
    check("idle_flush.valid", 32'(valid_out), 32'd0);
    check("idle_flush.count", 32'(group_count), 32'd2);
    check("idle_flush.mask", 32'(pad_mask), 32'(4'b1100));

    // Gapped bytes: only one strobe at the end.
    s0 = strobes;
    tick(1'b1, 8'hA1, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'hA2, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'hA3, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    check("gap.no_early", 32'(strobes - s0), 32'd0);
    tick(1'b1, 8'hA4, 1'b0);
    check_group("gap", 32'hA1A2A3A4, 4'b0000, 16'd3);

    // Flush with a byte in LANE0.
    tick(1'b1, 8'h55, 1'b1);
    check_group("flush_l0", 32'h55BCBCBC, 4'b1110, 16'd4);

    // Flush with a byte in LANE1.
    tick(1'b1, 8'h77, 1'b0);
    tick(1'b1, 8'h78, 1'b1);
    check_group("flush_l1v", 32'h7778BCBC, 4'b1100, 16'd5);

    // Flush with the fourth byte is a plain full group.
    tick(1'b1, 8'hC1, 1'b0);
    tick(1'b1, 8'hC2, 1'b0);
    tick(1'b1, 8'hC3, 1'b0);
    tick(1'b1, 8'hC4, 1'b1);
    check_group("flush_l3v", 32'hC1C2C3C4, 4'b0000, 16'd6);

    // Bare flush in LANE3.
    tick(1'b1, 8'hD1, 1'b0);
    tick(1'b1, 8'hD2, 1'b0);
    tick(1'b1, 8'hD3, 1'b0);
    tick(1'b0, 8'h00, 1'b1);
    check_group("flush_l3", 32'hD1D2D3BC, 4'b1000, 16'd7);

    // Back-to-back commits give consecutive strobes.
    tick(1'b1, 8'h9A, 1'b1);
    check_group("b2b.first", 32'h9ABCBCBC, 4'b1110, 16'd8);
    tick(1'b1, 8'h9B, 1'b1);
    check_group("b2b.second", 32'h9BBCBCBC, 4'b1110, 16'd9);

    // Partial group discarded by reset.
    tick(1'b1, 8'hE1, 1'b0);
    tick(1'b1, 8'hE2, 1'b0);
    tick(1'b1, 8'hE3, 1'b0);
    reset = 1'b1;
    tick(1'b1, 8'hE4, 1'b0);
    reset = 1'b0;
    check("rst2.count", 32'(group_count), 32'd0);
    check("rst2.valid", 32'(valid_out), 32'd0);
    s0 = strobes;
    tick(1'b1, 8'h66, 1'b0);
    tick(1'b1, 8'h67, 1'b0);
    tick(1'b1, 8'h68, 1'b0);
    tick(1'b1, 8'h69, 1'b0);
    check_group("rst2.group", 32'h66676869, 4'b0000, 16'd1);
    check("rst2.strobes", 32'(strobes - s0), 32'd1);

    // group_count wrap: 65534 more single-byte groups reach FFFF.
    for (int i = 0; i < 65534; i++) begin
      tick(1'b1, 8'(i), 1'b1);
    end
    check("wrap.pre", 32'(group_count), 32'h0000FFFF);
    tick(1'b1, 8'h5A, 1'b1);
    check_group("wrap", 32'h5ABCBCBC, 4'b1110, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
